// File: rtl/imem_port_arbiter.sv
// ----------------------------------------------------------------------------
// imem_port_arbiter
//
// Shares one single-port, synchronous-read 32-bit word memory between the
// instruction-fetch port (IF) and the load/store data port (DM).
//
// The data port normally wins when both ports request in the same cycle. An
// anti-starvation streak counter forces an IF grant once STARVE_LIMIT DM
// grants in a row have gone by while IF was waiting. Read data comes back one
// cycle after the grant, with a valid strobe for each port. Each port's rdata
// output holds its last read value between responses.
//
// Ports:
//   clk_i, rst_n_i        clock and asynchronous active-low reset
//   if_req_i/if_addr_i    fetch request and word address
//   if_gnt_o              fetch accepted this cycle
//   if_rvalid_o/if_rdata_o  fetch response (one cycle after grant)
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  data request
//   dm_gnt_o              data request accepted this cycle
//   dm_rvalid_o/dm_rdata_o  load data or write acknowledge
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  memory drive in grant cycle
//   mem_rdata_i           memory read data, valid the cycle after mem_en_o
// ----------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [31:0]       dm_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  streak_q, streak_d;
    logic        pend_if_q;
    logic        pend_dm_q;
    logic        dm_we_q;     // the outstanding DM access was a write
    logic [31:0] if_hold_q;
    logic [31:0] dm_hold_q;

    logic if_gnt, dm_gnt, starve;

    // Grants are gated by rst_n_i so that nothing reaches the memory while
    // reset is asserted, even though the reset itself is asynchronous.
    always_comb begin
        starve = if_req_i & (streak_q == LIMIT);
        dm_gnt = rst_n_i & dm_req_i & ~starve;
        if_gnt = rst_n_i & if_req_i & ~dm_gnt;
    end

    // The streak counts DM wins only while IF is actually waiting. When it
    // reaches the limit, DM is blocked for one cycle and IF is granted.
    always_comb begin
        streak_d = streak_q;
        if (!if_req_i || if_gnt) begin
            streak_d = 4'd0;
        end else if (dm_gnt && (streak_q != LIMIT)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_comb begin
        mem_en_o    = if_gnt | dm_gnt;
        mem_we_o    = dm_gnt & dm_we_i;
        mem_addr_o  = dm_gnt ? dm_addr_i  : if_addr_i;
        mem_wdata_o = dm_gnt ? dm_wdata_i : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            streak_q  <= 4'd0;
            pend_if_q <= 1'b0;
            pend_dm_q <= 1'b0;
            dm_we_q   <= 1'b0;
            if_hold_q <= 32'd0;
            dm_hold_q <= 32'd0;
        end else begin
            streak_q  <= streak_d;
            pend_if_q <= if_gnt;
            pend_dm_q <= dm_gnt;
            dm_we_q   <= dm_gnt & dm_we_i;
            if (pend_if_q) begin
                if_hold_q <= mem_rdata_i;
            end
            // A write acknowledge must not disturb the last load value.
            if (pend_dm_q && !dm_we_q) begin
                dm_hold_q <= mem_rdata_i;
            end
        end
    end

    assign if_gnt_o    = if_gnt;
    assign dm_gnt_o    = dm_gnt;
    assign if_rvalid_o = pend_if_q;
    assign dm_rvalid_o = pend_dm_q;
    assign if_rdata_o  = pend_if_q ? mem_rdata_i : if_hold_q;
    assign dm_rdata_o  = (pend_dm_q && !dm_we_q) ? mem_rdata_i : dm_hold_q;

endmodule
